// File: rtl/freq_meter_multi_if.sv
// Control, measured inputs and per-channel results of the multi-channel frequency meter.
interface freq_meter_multi_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 14
) ();
    logic                      en;
    logic                      mode;
    logic [CHANNELS-1:0]       signal;
    logic [CHANNELS*WIDTH-1:0] frequency;
    logic [CHANNELS-1:0]       valid;
    logic [CHANNELS-1:0]       overflow;

    modport master (
        output en,
        output mode,
        output signal,
        input  frequency,
        input  valid,
        input  overflow
    );

    modport slave (
        input  en,
        input  mode,
        input  signal,
        output frequency,
        output valid,
        output overflow
    );
endinterface

// File: rtl/freq_meter_multi.sv
// Multi-channel frequency/period meter: per-channel synchronizer and edge detector feeding
// a shared gate window (mode 0, edges per window) or per-channel period timers (mode 1).
module freq_meter_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 14,
    parameter int GATE_CYCLES = 100000,
    parameter int SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               rst,
    freq_meter_multi_if.slave bus
);
    localparam int              GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MAXV     = '1;

    logic [CHANNELS-1:0] sync_p [SYNC_STAGES];
    logic [CHANNELS-1:0] hist;
    logic [CHANNELS-1:0] edge_e;

    logic                mode_q;
    logic [GW-1:0]       gate_cnt, gate_nxt;
    logic                terminal;
    // Shared per channel: edge count in mode 0, elapsed cycles in mode 1.
    logic [WIDTH-1:0]    cnt_q   [CHANNELS];
    logic [WIDTH-1:0]    cnt_nxt [CHANNELS];
    logic [WIDTH-1:0]    res_q   [CHANNELS];
    logic [WIDTH-1:0]    res_nxt [CHANNELS];
    logic [CHANNELS-1:0] sat_q, sat_nxt;
    logic [CHANNELS-1:0] armed_q, armed_nxt;
    logic [CHANNELS-1:0] ovf_q, ovf_nxt;
    logic [CHANNELS-1:0] vld_q, vld_nxt;

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] v, input logic inc);
        return (inc && (v != MAXV)) ? v + WIDTH'(1) : v;
    endfunction

    function automatic logic sat_hit(input logic [WIDTH-1:0] v, input logic inc);
        return inc && (v == MAXV);
    endfunction

    // Synchronizer and history stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
            hist <= '0;
        end else begin
            sync_p[0] <= bus.signal;
            for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
            hist <= sync_p[SYNC_STAGES-1];
        end
    end

    assign edge_e = sync_p[SYNC_STAGES-1] & ~hist;

    // Measurement next-state
    always_comb begin
        gate_nxt  = gate_cnt;
        terminal  = 1'b0;
        cnt_nxt   = cnt_q;
        res_nxt   = res_q;
        sat_nxt   = sat_q;
        armed_nxt = armed_q;
        ovf_nxt   = ovf_q;
        vld_nxt   = '0;
        if (!bus.en || (bus.mode != mode_q)) begin
            // Disabled or mode just changed: drop any partial measurement.
            gate_nxt  = '0;
            sat_nxt   = '0;
            armed_nxt = '0;
            for (int i = 0; i < CHANNELS; i++) cnt_nxt[i] = '0;
        end else if (!bus.mode) begin
            terminal  = (gate_cnt == GATE_LAST);
            gate_nxt  = terminal ? '0 : gate_cnt + GW'(1);
            armed_nxt = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (terminal) begin
                    res_nxt[i] = sat_add(cnt_q[i], edge_e[i]);
                    ovf_nxt[i] = sat_q[i] | sat_hit(cnt_q[i], edge_e[i]);
                    vld_nxt[i] = 1'b1;
                    cnt_nxt[i] = '0;
                    sat_nxt[i] = 1'b0;
                end else begin
                    cnt_nxt[i] = sat_add(cnt_q[i], edge_e[i]);
                    sat_nxt[i] = sat_q[i] | sat_hit(cnt_q[i], edge_e[i]);
                end
            end
        end else begin
            gate_nxt = '0;
            sat_nxt  = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (edge_e[i]) begin
                    cnt_nxt[i]   = '0;
                    armed_nxt[i] = 1'b1;
                    if (armed_q[i]) begin
                        res_nxt[i] = sat_add(cnt_q[i], 1'b1);
                        ovf_nxt[i] = sat_hit(cnt_q[i], 1'b1);
                        vld_nxt[i] = 1'b1;
                    end
                end else begin
                    cnt_nxt[i] = sat_add(cnt_q[i], 1'b1);
                end
            end
        end
    end

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= 1'b0;
            gate_cnt <= '0;
            cnt_q    <= '{default: '0};
            res_q    <= '{default: '0};
            sat_q    <= '0;
            armed_q  <= '0;
            ovf_q    <= '0;
            vld_q    <= '0;
        end else begin
            mode_q   <= bus.mode;
            gate_cnt <= gate_nxt;
            cnt_q    <= cnt_nxt;
            res_q    <= res_nxt;
            sat_q    <= sat_nxt;
            armed_q  <= armed_nxt;
            ovf_q    <= ovf_nxt;
            vld_q    <= vld_nxt;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_out
        assign bus.frequency[i*WIDTH +: WIDTH] = res_q[i];
    end
    assign bus.valid    = vld_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_freq_meter_multi.sv
// Randomized bench for freq_meter_multi: two widths driven in parallel, results compared
// against an edge-timeline reference model (window edge counts and edge-to-edge periods).
module tb_freq_meter_multi;
    localparam int CH   = 4;
    localparam int G    = 100;
    localparam int S    = 2;
    localparam int WA   = 14;
    localparam int WB   = 4;
    localparam int MAXC = 5200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    freq_meter_multi_if #(.CHANNELS(CH), .WIDTH(WA)) bus_a ();
    freq_meter_multi_if #(.CHANNELS(CH), .WIDTH(WB)) bus_b ();

    freq_meter_multi #(.CHANNELS(CH), .WIDTH(WA), .GATE_CYCLES(G), .SYNC_STAGES(S)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave));
    freq_meter_multi #(.CHANNELS(CH), .WIDTH(WB), .GATE_CYCLES(G), .SYNC_STAGES(S)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave));

    int n_chk = 0;
    int n_fail = 0;

    // Stimulus state
    logic          en_v, mode_v;
    logic [CH-1:0] sig_v;
    int            per [CH];
    int            ph  [CH];

    // Reference timeline: posedge index at which each edge gets counted, en/mode per posedge
    bit edge_at [CH][MAXC];
    bit en_at   [MAXC];
    bit mode_at [MAXC];
    int cyc, last_clr;
    int prev_edge [CH];
    int exp_fa [CH], exp_fb [CH];
    bit exp_oa [CH], exp_ob [CH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int satv(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < MAXC; t++) begin
            en_at[t] = 1'b0;
            mode_at[t] = 1'b0;
            for (int i = 0; i < CH; i++) edge_at[i][t] = 1'b0;
        end
        cyc = 0;
        last_clr = 0;
        sig_v = '0;
        for (int i = 0; i < CH; i++) begin
            prev_edge[i] = -1;
            exp_fa[i] = 0; exp_fb[i] = 0;
            exp_oa[i] = 1'b0; exp_ob[i] = 1'b0;
        end
    endtask

    task automatic set_ch(input int i, input int p, input int phase);
        per[i] = p;
        ph[i]  = (p > 0) ? phase % p : 0;
    endtask

    task automatic compare_outputs(input logic [CH-1:0] vexp, input string where);
        chk($sformatf("valid_a %s@%0d", where, cyc), 32'(bus_a.valid), 32'(vexp));
        chk($sformatf("valid_b %s@%0d", where, cyc), 32'(bus_b.valid), 32'(vexp));
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("freq_a[%0d] %s@%0d", i, where, cyc), 32'(bus_a.frequency[i*WA +: WA]), 32'(exp_fa[i]));
            chk($sformatf("freq_b[%0d] %s@%0d", i, where, cyc), 32'(bus_b.frequency[i*WB +: WB]), 32'(exp_fb[i]));
            chk($sformatf("ovf_a[%0d] %s@%0d", i, where, cyc), 32'(bus_a.overflow[i]), 32'(exp_oa[i]));
            chk($sformatf("ovf_b[%0d] %s@%0d", i, where, cyc), 32'(bus_b.overflow[i]), 32'(exp_ob[i]));
        end
    endtask

    task automatic apply_inputs();
        bus_a.en = en_v;   bus_b.en = en_v;
        bus_a.mode = mode_v; bus_b.mode = mode_v;
        bus_a.signal = sig_v; bus_b.signal = sig_v;
    endtask

    // Drive inputs for the next posedge and record where each rising edge will be counted
    task automatic drive();
        int a;
        logic hi;
        a = cyc + 1;
        en_at[a] = en_v;
        mode_at[a] = mode_v;
        for (int i = 0; i < CH; i++) begin
            hi = (per[i] >= 2) && (((a + S - ph[i] + per[i] * 1000) % per[i]) < per[i] / 2);
            if (hi && !sig_v[i]) edge_at[i][a + S] = 1'b1;
            sig_v[i] = hi;
        end
        apply_inputs();
    endtask

    task automatic evaluate_and_check();
        logic [CH-1:0] vexp;
        int t, n, d;
        t = cyc;
        vexp = '0;
        if (!en_at[t] || (mode_at[t] != mode_at[t-1])) begin
            last_clr = t;
        end else if (!mode_at[t]) begin
            if ((t - last_clr) % G == 0) begin
                for (int i = 0; i < CH; i++) begin
                    n = 0;
                    for (int k = t - G + 1; k <= t; k++) n += int'(edge_at[i][k]);
                    vexp[i] = 1'b1;
                    exp_fa[i] = satv(n, WA); exp_oa[i] = (n > (1 << WA) - 1);
                    exp_fb[i] = satv(n, WB); exp_ob[i] = (n > (1 << WB) - 1);
                end
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (edge_at[i][t] && (prev_edge[i] > last_clr)) begin
                    d = t - prev_edge[i];
                    vexp[i] = 1'b1;
                    exp_fa[i] = satv(d, WA); exp_oa[i] = (d > (1 << WA) - 1);
                    exp_fb[i] = satv(d, WB); exp_ob[i] = (d > (1 << WB) - 1);
                end
            end
        end
        for (int i = 0; i < CH; i++) if (edge_at[i][t]) prev_edge[i] = t;
        compare_outputs(vexp, "run");
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            drive();
            @(negedge clk);
            cyc++;
            evaluate_and_check();
        end
    endtask

    initial begin
        en_v = 1'b0; mode_v = 1'b0; sig_v = '0;
        for (int i = 0; i < CH; i++) set_ch(i, 0, 0);
        apply_inputs();
        repeat (3) @(negedge clk);
        model_reset();
        compare_outputs('0, "reset");
        rst = 1'b0;

        // Mode 0: ch0 every 10 clk, others idle
        en_v = 1'b1; mode_v = 1'b0;
        set_ch(0, 10, 3);
        run(350);

        // ch1 fast enough to saturate the narrow instance; ch2 edges land on terminal cycles
        set_ch(1, 2, 0);
        set_ch(2, 10, 0);
        run(300);

        // Mode switch mid-window, then period measurement
        mode_v = 1'b1;
        run(250);

        // Randomized segments: enable, mode and per-channel periods
        for (int seg = 0; seg < 8; seg++) begin
            en_v = ($urandom_range(0, 4) != 0);
            mode_v = 1'($urandom_range(0, 1));
            for (int i = 0; i < CH; i++)
                set_ch(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 40)), int'($urandom_range(0, 39)));
            run(int'($urandom_range(150, 400)));
        end

        // Asynchronous reset mid-window
        en_v = 1'b1; mode_v = 1'b0;
        set_ch(0, 10, 7);
        for (int i = 1; i < CH; i++) set_ch(i, 0, 0);
        run(150);
        rst = 1'b1;
        #1;
        model_reset();
        compare_outputs('0, "async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run(350);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
